// File: rtl/tri_vertex_loader_pkg.sv
// Shared definitions for the triangle vertex loader: default coordinate
// width and the controller state encoding.
package tri_vertex_loader_pkg;

    localparam int COORD_W_DEF = 3;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD2 = 3'd1,
        LOAD3 = 3'd2,
        PRIME = 3'd3,
        SCAN  = 3'd4,
        DONE  = 3'd5
    } state_t;

endpackage

// File: rtl/tri_vertex_loader.sv
// Triangle front-end controller: captures three sequential vertices, holds
// them for the bounding-box scanner, sequences the scanner's run input and
// reports busy to the host until the scanner signals finish.
// Optional build macro TRI_VERTEX_CHECK_EN enables the illegal-triangle check
// (X3 == X1 and Y1 <= Y2 <= Y3); without it err is tied low.
module tri_vertex_loader
    import tri_vertex_loader_pkg::*;
#(
    parameter int COORD_W = COORD_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               nt,
    input  logic [COORD_W-1:0] xi,
    input  logic [COORD_W-1:0] yi,
    input  logic               finish,
    output logic               busy,
    output logic               run,
    output logic [COORD_W-1:0] X1,
    output logic [COORD_W-1:0] Y1,
    output logic [COORD_W-1:0] X2,
    output logic [COORD_W-1:0] Y2,
    output logic [COORD_W-1:0] X3,
    output logic [COORD_W-1:0] Y3,
    output logic               err
);

    state_t state, state_n;

`ifdef TRI_VERTEX_CHECK_EN
    // Vertex 3 is still on xi/yi when LOAD3 exits, so it is checked unregistered.
    logic vert_ok;
    assign vert_ok = (xi == X1) && (Y1 <= Y2) && (Y2 <= yi);
`endif

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_n;
    end

    // Next-state logic; finish is only honoured in SCAN.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:  if (nt) state_n = LOAD2;
            LOAD2: state_n = LOAD3;
`ifdef TRI_VERTEX_CHECK_EN
            LOAD3: state_n = vert_ok ? PRIME : DONE;
`else
            LOAD3: state_n = PRIME;
`endif
            PRIME: state_n = SCAN;
            SCAN:  if (finish) state_n = DONE;
            DONE:  state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Vertex capture; registers hold until the next accepted triangle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            X1 <= '0; Y1 <= '0;
            X2 <= '0; Y2 <= '0;
            X3 <= '0; Y3 <= '0;
        end else begin
            case (state)
                IDLE:  if (nt) begin X1 <= xi; Y1 <= yi; end
                LOAD2: begin X2 <= xi; Y2 <= yi; end
                LOAD3: begin X3 <= xi; Y3 <= yi; end
                default: ;
            endcase
        end
    end

`ifdef TRI_VERTEX_CHECK_EN
    // Error flag: cleared on acceptance, set on a failed vertex check.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                        err <= 1'b0;
        else if (state == IDLE && nt)    err <= 1'b0;
        else if (state == LOAD3 && !vert_ok) err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

    // Outputs decoded straight from the state register.
    assign busy = (state != IDLE);
    assign run  = (state == SCAN);

endmodule

// File: tb/tb_tri_vertex_loader.sv
// Self-checking bench for tri_vertex_loader. Each triangle is described by
// its vertices and the number of SCAN cycles the scanner takes; expected
// busy/run/err/vertex values per cycle follow from the timing rules.
module tb_tri_vertex_loader;
    localparam int W = 3;

    logic         clk = 1'b0;
    logic         rst, nt, finish;
    logic [W-1:0] xi, yi;
    logic         busy, run, err;
    logic [W-1:0] X1, Y1, X2, Y2, X3, Y3;

    int total = 0;
    int bad   = 0;

    logic [W-1:0] mv [6];
    logic         merr;

    tri_vertex_loader #(.COORD_W(W)) dut (
        .clk(clk), .rst(rst), .nt(nt), .xi(xi), .yi(yi), .finish(finish),
        .busy(busy), .run(run),
        .X1(X1), .Y1(Y1), .X2(X2), .Y2(Y2), .X3(X3), .Y3(Y3),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input bit eb, input bit er);
        chk({tag, ".busy"}, 32'(busy), 32'(eb));
        chk({tag, ".run"},  32'(run),  32'(er));
        chk({tag, ".err"},  32'(err),  32'(merr));
        chk({tag, ".X1"}, 32'(X1), 32'(mv[0]));
        chk({tag, ".Y1"}, 32'(Y1), 32'(mv[1]));
        chk({tag, ".X2"}, 32'(X2), 32'(mv[2]));
        chk({tag, ".Y2"}, 32'(Y2), 32'(mv[3]));
        chk({tag, ".X3"}, 32'(X3), 32'(mv[4]));
        chk({tag, ".Y3"}, 32'(Y3), 32'(mv[5]));
    endtask

    task automatic model_reset();
        for (int i = 0; i < 6; i++) mv[i] = '0;
        merr = 1'b0;
    endtask

    // One triangle: nt at edge 0, s SCAN cycles, optional junk on nt/finish
    // while busy, optional asynchronous reset in cycle abort_at (0 = none).
    task automatic tri_run(input string tag,
                           input logic [W-1:0] x1, input logic [W-1:0] y1,
                           input logic [W-1:0] x2, input logic [W-1:0] y2,
                           input logic [W-1:0] x3, input logic [W-1:0] y3,
                           input int s, input bit noise, input int abort_at);
        bit viol;
        int last;
`ifdef TRI_VERTEX_CHECK_EN
        viol = !((x3 == x1) && (y1 <= y2) && (y2 <= y3));
`else
        viol = 1'b0;
`endif
        last = viol ? 3 : 4 + s;
        for (int t = 0; t <= last + 1; t++) begin
            @(negedge clk);
            if (t == 1) begin mv[0] = x1; mv[1] = y1; merr = 1'b0; end
            if (t == 2) begin mv[2] = x2; mv[3] = y2; end
            if (t == 3) begin mv[4] = x3; mv[5] = y3; if (viol) merr = 1'b1; end
            chk_outs($sformatf("%s.c%0d", tag, t), (t >= 1 && t <= last),
                     (!viol && t >= 4 && t <= 3 + s));
            if (t == abort_at) begin
                #2 rst = 1'b0;
                #1;
                model_reset();
                chk_outs($sformatf("%s.rst", tag), 1'b0, 1'b0);
                @(negedge clk);
                rst = 1'b1; nt = 1'b0; finish = 1'b0;
                return;
            end
            // inputs for edge t
            case (t)
                0: begin nt = 1'b1; xi = x1; yi = y1; end
                1: begin xi = x2; yi = y2; nt = noise ? 1'($urandom) : 1'b0; end
                2: begin xi = x3; yi = y3; nt = noise ? 1'($urandom) : 1'b0; end
                default: begin
                    xi = W'($urandom); yi = W'($urandom);
                    nt = (noise && t <= last) ? 1'($urandom) : 1'b0;
                end
            endcase
            if (!viol && t >= 4 && t <= 3 + s) finish = (t == 3 + s);
            else finish = noise ? 1'($urandom) : 1'b0;
        end
        nt = 1'b0; finish = 1'b0;
    endtask

    initial begin
        logic [W-1:0] v [6];
        logic [W-1:0] tmp;
        model_reset();
        rst = 1'b0; nt = 1'b1; xi = 3'd5; yi = 3'd6; finish = 1'b0;
        @(negedge clk);
        chk_outs("reset0", 1'b0, 1'b0);
        nt = 1'b0;
        @(negedge clk);
        chk_outs("reset1", 1'b0, 1'b0);
        rst = 1'b1;

        tri_run("normal",  1, 0, 4, 2, 1, 3, 13, 1'b0, 0);
        tri_run("lockout", 1, 0, 4, 2, 1, 3, 5,  1'b1, 0);
        tri_run("single",  2, 5, 2, 5, 2, 5, 1,  1'b0, 0);
        tri_run("abort",   1, 0, 4, 2, 1, 3, 13, 1'b0, 6);
        tri_run("after",   3, 1, 6, 2, 3, 7, 4,  1'b0, 0);
        tri_run("chkstim", 1, 0, 4, 2, 3, 3, 5,  1'b0, 0);
        tri_run("clear",   1, 0, 4, 2, 1, 3, 2,  1'b1, 0);

        for (int n = 0; n < 24; n++) begin
            for (int i = 0; i < 6; i++) v[i] = W'($urandom);
            if ($urandom_range(1, 0) == 1) begin
                v[4] = v[0];
                if (v[1] > v[3]) begin tmp = v[1]; v[1] = v[3]; v[3] = tmp; end
                if (v[3] > v[5]) begin tmp = v[3]; v[3] = v[5]; v[5] = tmp; end
                if (v[1] > v[3]) begin tmp = v[1]; v[1] = v[3]; v[3] = tmp; end
            end
            tri_run($sformatf("rnd%0d", n), v[0], v[1], v[2], v[3], v[4], v[5],
                    $urandom_range(15, 1), 1'($urandom), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
